// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, stall and
// enable encodings, icache geometry and the fetch FSM state type.
package inst_fetch_pkg;

    typedef logic [5:0]  StallBus;
    typedef logic [31:0] InstAddrBus;
    typedef logic [31:0] InstBus;

    localparam logic   Stop     = 1'b1;
    localparam logic   NoStop   = 1'b0;
    localparam logic   Enable   = 1'b1;
    localparam logic   Disable  = 1'b0;
    localparam InstBus ZeroWord = 32'h0000_0000;

    // Direct-mapped icache: index pc[7:2], tag pc[17:8].
    localparam int ICacheEntries = 64;
    typedef logic [5:0] ICacheIndexBus;
    typedef logic [9:0] ICacheTagBus;

    // IDLE: icache lookup, B0..B3: byte n being read, HOLD: word on the outputs.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        B2   = 3'd3,
        B3   = 3'd4,
        HOLD = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Byte-wide read bus between the fetch stage (master) and the memory
// controller (slave).
//
// Handshake: the master raises mem_req with a stable mem_addr and keeps both
// unchanged until the slave answers with mem_valid=1 and the byte on mem_data
// in the same cycle. A cycle with mem_valid=1 completes the transfer; the
// master may then change mem_addr or drop mem_req. mem_valid while mem_req=0
// carries no meaning and is ignored by the master.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic       mem_req;
    InstAddrBus mem_addr;
    logic       mem_valid;
    logic [7:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_valid,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_valid,
        output mem_data
    );

endinterface

// File: rtl/inst_fetch_icache.sv
// 64-entry direct-mapped instruction cache: combinational read, one
// synchronous write port. Reset invalidates every entry; tag and data
// storage are left unreset since valid gates their use.
module inst_fetch_icache
    import inst_fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  ICacheIndexBus rd_index,
    input  ICacheTagBus   rd_tag,
    output logic          rd_hit,
    output InstBus        rd_data,
    input  logic          wr_en,
    input  ICacheIndexBus wr_index,
    input  ICacheTagBus   wr_tag,
    input  InstBus        wr_data
);

    logic [ICacheEntries-1:0] valid_q;
    ICacheTagBus              tag_q  [ICacheEntries];
    InstBus                   data_q [ICacheEntries];

    // Lookup: hit when the indexed entry is valid and its tag matches.
    always_comb begin
        rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
        rd_data = data_q[rd_index];
    end

    // Valid bits: cleared on reset, set when a complete word is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage for the written entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: delivers one 32-bit instruction at a time to ID,
// served from the icache when possible, otherwise assembled little-endian
// from four byte reads. A branch from EX redirects the PC and drops any
// fetch in progress.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  StallBus           stall,
    input  logic              branch_from_ex,
    input  InstAddrBus        branch_target,
    inst_fetch_if.master      mem,
    output logic              if_flag,
    output InstAddrBus        if_pc,
    output InstBus            if_inst,
    output fetch_state_e      dbg_state
);

    fetch_state_e state_q, state_d;
    InstAddrBus   pc_q, pc_d;
    InstAddrBus   pc_plus4;
    logic [23:0]  low_bytes_q, low_bytes_d;
    logic         flag_d;
    InstAddrBus   ipc_d;
    InstBus       inst_d;

    logic          in_fetch;
    logic [1:0]    byte_sel;
    ICacheIndexBus rd_index;
    ICacheTagBus   rd_tag;
    logic          rd_hit;
    InstBus        rd_data;
    logic          cache_we;
    InstBus        full_word;

    // Only stall[1] matters to this stage.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5:2], stall[0]};

    assign pc_plus4  = pc_q + 32'd4;
    assign full_word = {mem.mem_data, low_bytes_q};
    assign dbg_state = state_q;

    // Byte lane of the current memory read; HOLD looks up the next PC.
    always_comb begin
        in_fetch = 1'b0;
        byte_sel = 2'd0;
        case (state_q)
            B0:      begin in_fetch = 1'b1; byte_sel = 2'd0; end
            B1:      begin in_fetch = 1'b1; byte_sel = 2'd1; end
            B2:      begin in_fetch = 1'b1; byte_sel = 2'd2; end
            B3:      begin in_fetch = 1'b1; byte_sel = 2'd3; end
            default: begin in_fetch = 1'b0; byte_sel = 2'd0; end
        endcase
        if (state_q == HOLD) begin
            rd_index = pc_plus4[7:2];
            rd_tag   = pc_plus4[17:8];
        end else begin
            rd_index = pc_q[7:2];
            rd_tag   = pc_q[17:8];
        end
    end

    // Memory request: a redirect or reset in this cycle kills the request.
    always_comb begin
        mem.mem_req  = in_fetch && !branch_from_ex && !rst;
        mem.mem_addr = pc_q | {30'd0, byte_sel};
    end

    // Next-state and output logic; the redirect overrides every other event.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        low_bytes_d = low_bytes_q;
        flag_d      = if_flag;
        ipc_d       = if_pc;
        inst_d      = if_inst;
        cache_we    = 1'b0;
        if (branch_from_ex) begin
            pc_d    = branch_target & 32'hFFFF_FFFC;
            flag_d  = 1'b0;
            ipc_d   = ZeroWord;
            inst_d  = ZeroWord;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_hit) begin
                        flag_d  = 1'b1;
                        ipc_d   = pc_q;
                        inst_d  = rd_data;
                        state_d = HOLD;
                    end else begin
                        state_d = B0;
                    end
                end
                B0: if (mem.mem_valid) begin
                    low_bytes_d[7:0] = mem.mem_data;
                    state_d          = B1;
                end
                B1: if (mem.mem_valid) begin
                    low_bytes_d[15:8] = mem.mem_data;
                    state_d           = B2;
                end
                B2: if (mem.mem_valid) begin
                    low_bytes_d[23:16] = mem.mem_data;
                    state_d            = B3;
                end
                B3: if (mem.mem_valid) begin
                    flag_d   = 1'b1;
                    ipc_d    = pc_q;
                    inst_d   = full_word;
                    cache_we = 1'b1;
                    state_d  = HOLD;
                end
                HOLD: if (stall[1] == NoStop) begin
                    pc_d = pc_plus4;
                    if (rd_hit) begin
                        ipc_d  = pc_plus4;
                        inst_d = rd_data;
                    end else begin
                        flag_d  = 1'b0;
                        state_d = B0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, PC, byte latches and delivered-instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= ZeroWord;
            low_bytes_q <= '0;
            if_flag     <= 1'b0;
            if_pc       <= ZeroWord;
            if_inst     <= ZeroWord;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            low_bytes_q <= low_bytes_d;
            if_flag     <= flag_d;
            if_pc       <= ipc_d;
            if_inst     <= inst_d;
        end
    end

    inst_fetch_icache u_icache (
        .clk      (clk),
        .rst      (rst),
        .rd_index (rd_index),
        .rd_tag   (rd_tag),
        .rd_hit   (rd_hit),
        .rd_data  (rd_data),
        .wr_en    (cache_we && !rst),
        .wr_index (pc_q[7:2]),
        .wr_tag   (pc_q[17:8]),
        .wr_data  (full_word)
    );

endmodule
